// File: rtl/regbank_writeback_queue.sv
// regbank_writeback_queue: FIFO of register write-backs drained one per unheld cycle onto the bank write port.
// Defining WBQ_BYPASS_EN adds forwarding of the youngest pending value to the two bank read ports.
module regbank_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [4:0]    InRg,
  input  logic [31:0]   InData,
  input  logic          Hold,
  output logic [4:0]    WriteRg,
  output logic [31:0]   WriteData,
  output logic          RegWrite,
  output logic [AW:0]   Occupancy,
  input  logic [4:0]    LookRg1,
  input  logic [4:0]    LookRg2,
  output logic          Fwd1Hit,
  output logic [31:0]   Fwd1Data,
  output logic          Fwd2Hit,
  output logic [31:0]   Fwd2Data
);
  logic [4:0]    rgQ   [DEPTH];
  logic [31:0]   dataQ [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic [AW:0]   count;
  logic          push, pop;
  assign Occupancy = count;
  assign InReady   = count != (AW+1)'(DEPTH);
  assign pop       = (count != '0) && !Hold;
  // Writes to r0 are acknowledged but dropped, so they never occupy a slot.
  assign push      = InValid && InReady && (InRg != 5'd0);
  assign RegWrite  = pop;
  assign WriteRg   = pop ? rgQ[rdPtr] : 5'd0;
  assign WriteData = pop ? dataQ[rdPtr] : 32'd0;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        rgQ[wrPtr]   <= InRg;
        dataQ[wrPtr] <= InData;
        wrPtr        <= wrPtr + AW'(1);
      end
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef WBQ_BYPASS_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [32:0] lookup(input logic [4:0] rg);
    logic [32:0]   r;
    logic [AW-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + AW'(i);
      if (rg != 5'd0 && (AW+1)'(i) < count && rgQ[idx] == rg) r = {1'b1, dataQ[idx]};
    end
    return r;
  endfunction
  always_comb begin
    {Fwd1Hit, Fwd1Data} = lookup(LookRg1);
    {Fwd2Hit, Fwd2Data} = lookup(LookRg2);
  end
`else
  logic unusedLook;
  assign unusedLook = ^{LookRg1, LookRg2};
  assign Fwd1Hit  = 1'b0;
  assign Fwd1Data = 32'd0;
  assign Fwd2Hit  = 1'b0;
  assign Fwd2Data = 32'd0;
`endif
endmodule

// File: tb/tb_regbank_writeback_queue.sv
// tb_regbank_writeback_queue: table vectors plus randomized traffic against a queue-based reference model.
module tb_regbank_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW = 2;
`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic Clock, Reset, InValid, InReady, Hold, RegWrite;
  logic Fwd1Hit, Fwd2Hit;
  logic [4:0] InRg, WriteRg, LookRg1, LookRg2;
  logic [31:0] InData, WriteData, Fwd1Data, Fwd2Data;
  logic [AW:0] Occupancy;

  regbank_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRg(InRg), .InData(InData), .Hold(Hold), .WriteRg(WriteRg),
    .WriteData(WriteData), .RegWrite(RegWrite), .Occupancy(Occupancy),
    .LookRg1(LookRg1), .LookRg2(LookRg2), .Fwd1Hit(Fwd1Hit), .Fwd1Data(Fwd1Data),
    .Fwd2Hit(Fwd2Hit), .Fwd2Data(Fwd2Data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] data;
  } ent_t;
  typedef struct {
    logic rst, v;
    logic [4:0] rg;
    logic [31:0] data;
    logic hold;
    logic [4:0] l1, l2;
    logic eReady, eRw;
    logic [4:0] eRg;
    logic [31:0] eData;
    logic [AW:0] eOcc;
    logic eHit;
    logic [31:0] eFwd;
  } vec_t;

  ent_t mq[$];
  logic [31:0] tbBank [32];
  logic [31:0] modelBank [32];
  vec_t tbl [26];
  int checks = 0, errors = 0, commits = 0;
  logic sRw;
  logic [4:0] sRg;
  logic [31:0] sData;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic rst, logic v, logic [4:0] rg, logic [31:0] data, logic hold,
                              logic [4:0] l1, logic [4:0] l2, logic eReady, logic eRw, logic [4:0] eRg,
                              logic [31:0] eData, logic [AW:0] eOcc, logic eHit, logic [31:0] eFwd);
    vec_t t;
    t.rst = rst; t.v = v; t.rg = rg; t.data = data; t.hold = hold; t.l1 = l1; t.l2 = l2;
    t.eReady = eReady; t.eRw = eRw; t.eRg = eRg; t.eData = eData; t.eOcc = eOcc;
    t.eHit = eHit; t.eFwd = eFwd;
    return t;
  endfunction

  task automatic fwdExp(input logic [4:0] rg, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d = 32'd0;
    if (BYP && rg != 5'd0)
      foreach (mq[i]) if (mq[i].rg == rg) begin
        hit = 1'b1;
        d = mq[i].data;
      end
  endtask

  task automatic settle(input bit doCheck);
    logic eRw, h;
    logic [31:0] d;
    #1;
    sRw = RegWrite; sRg = WriteRg; sData = WriteData;
    if (doCheck) begin
      eRw = mq.size() > 0 && !Hold;
      chk("occupancy", 64'(Occupancy), 64'(mq.size()));
      chk("inready", 64'(InReady), 64'(mq.size() != DEPTH));
      chk("regwrite", 64'(RegWrite), 64'(eRw));
      chk("writerg", 64'(WriteRg), eRw ? 64'(mq[0].rg) : 64'd0);
      chk("writedata", 64'(WriteData), eRw ? 64'(mq[0].data) : 64'd0);
      fwdExp(LookRg1, h, d);
      chk("fwd1", {31'd0, Fwd1Hit, Fwd1Data}, {31'd0, h, d});
      fwdExp(LookRg2, h, d);
      chk("fwd2", {31'd0, Fwd2Hit, Fwd2Data}, {31'd0, h, d});
    end
  endtask

  task automatic edgeStep();
    bit popNow, pushNow;
    @(posedge Clock);
    popNow = mq.size() > 0 && !Hold;
    pushNow = InValid && mq.size() != DEPTH && InRg != 5'd0;
    if (sRw === 1'b1) begin
      tbBank[sRg] = sData;
      commits++;
    end
    if (Reset) mq.delete();
    else begin
      if (popNow) begin
        modelBank[mq[0].rg] = mq[0].data;
        void'(mq.pop_front());
      end
      if (pushNow) mq.push_back('{InRg, InData});
    end
    @(negedge Clock);
  endtask

  task automatic drive(logic rst, logic v, logic [4:0] rg, logic [31:0] data, logic hold,
                       logic [4:0] l1, logic [4:0] l2);
    Reset = rst; InValid = v; InRg = rg; InData = data; Hold = hold; LookRg1 = l1; LookRg2 = l2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    foreach (tbBank[i]) begin
      tbBank[i] = 32'd0;
      modelBank[i] = 32'd0;
    end
    tbl[0] = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 0, 5, 0, 1, 1, 5, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF);
    tbl[2] = mk(0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(0, 1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      tbl[4+i] = mk(0, 1, 5'(i), 32'h100 + 32'(i), 1, 0, 0, (i != 5), 0, 0, 0, (AW+1)'(i-1), 0, 0);
    for (int i = 1; i <= 4; i++)
      tbl[9+i] = mk(0, 0, 0, 0, 0, 0, 0, (i != 1), 1, 5'(i), 32'h100 + 32'(i), (AW+1)'(5-i), 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 7, 32'h11, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 7, 32'h22, 1, 7, 0, 1, 0, 0, 0, 1, 1, 32'h11);
    tbl[17] = mk(0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 0, 2, 1, 32'h22);
    tbl[18] = mk(0, 0, 0, 0, 0, 7, 0, 1, 1, 7, 32'h11, 2, 1, 32'h22);
    tbl[19] = mk(0, 0, 0, 0, 0, 7, 0, 1, 1, 7, 32'h22, 1, 1, 32'h22);
    tbl[20] = mk(0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      tbl[21+k] = mk(0, 1, 5'(9+k), 32'hA0 + 32'(k), 1, 0, 0, 1, 0, 0, 0, (AW+1)'(k), 0, 0);
    tbl[24] = mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 3, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 1, 0, 0);
    @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      settle(0);
      edgeStep();
    end
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].rg, tbl[i].data, tbl[i].hold, tbl[i].l1, tbl[i].l2);
      settle(1);
      chk($sformatf("v%0d.ready", i), 64'(InReady), 64'(tbl[i].eReady));
      chk($sformatf("v%0d.rw", i), 64'(RegWrite), 64'(tbl[i].eRw));
      chk($sformatf("v%0d.rg", i), 64'(WriteRg), 64'(tbl[i].eRg));
      chk($sformatf("v%0d.data", i), 64'(WriteData), 64'(tbl[i].eData));
      chk($sformatf("v%0d.occ", i), 64'(Occupancy), 64'(tbl[i].eOcc));
      chk($sformatf("v%0d.fwd", i), {31'd0, Fwd1Hit, Fwd1Data},
          {31'd0, tbl[i].eHit & BYP, BYP ? tbl[i].eFwd : 32'd0});
      edgeStep();
    end
    chk("bank.r5", 64'(tbBank[5]), 64'hDEADBEEF);
    chk("bank.r0", 64'(tbBank[0]), 64'd0);
    for (int i = 1; i <= 4; i++) chk($sformatf("bank.r%0d", i), 64'(tbBank[i]), 64'h100 + 64'(i));
    chk("bank.r7", 64'(tbBank[7]), 64'h22);
    chk("bank.r9", 64'(tbBank[9]), 64'd0);
    chk("bank.r10", 64'(tbBank[10]), 64'd0);

    // Full queue, then continuous traffic with the drain running.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5'($urandom_range(1, 31)), $urandom, 1, 0, 0);
      settle(1);
      edgeStep();
    end
    n = commits;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 5'($urandom_range(1, 31)), $urandom, 0, 5'($urandom_range(0, 31)), 0);
      settle(1);
      edgeStep();
    end
    chk("t6.commits", 64'(commits - n), 64'd12);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      settle(1);
      edgeStep();
    end
    chk("t6.empty", 64'(Occupancy), 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      drive(r, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
            r ? 1'b1 : ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      settle(1);
      edgeStep();
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      settle(1);
      edgeStep();
    end
    for (int i = 0; i < 32; i++) chk($sformatf("final.r%0d", i), 64'(tbBank[i]), 64'(modelBank[i]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
